// File: rtl/s2p_frame_ctrl.sv
// Receive-side serial frame sequencer: start-bit hunt, LSB-first data capture,
// stop-bit check, and a 1-deep valid/ready output buffer with error/overrun pulses.
module s2p_frame_ctrl #(
    parameter int DATA_W = 8,
    parameter int STOP_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic              Clock,
    input  logic              iReset,
    input  logic              i1b,
    input  logic              iEnable,
    input  logic              iReady,
    output logic [DATA_W-1:0] oData,
    output logic              oValid,
    output logic              oBusy,
    output logic              oFrameErr,
    output logic              oOverrun,
    output logic [CNT_W-1:0]  oFrameCount
);

    localparam int BC_MAX = (DATA_W > STOP_W) ? DATA_W : STOP_W;
    localparam int BC_W   = (BC_MAX < 2) ? 1 : $clog2(BC_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_STOP,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [BC_W-1:0]     bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ferr_q, ferr_d;
    logic                ovr_q, ovr_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge Clock or negedge iReset) begin
        if (!iReset) begin
            state_q  <= S_IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;

        if (valid_q && iReady) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                // The detecting edge is itself the start-bit sample.
                if (!i1b && iEnable) begin
                    state_d  = S_DATA;
                    bitcnt_d = '0;
                end
            end
            S_DATA: begin
                shift_d[bitcnt_q] = i1b;
                if (bitcnt_q == BC_W'(DATA_W - 1)) begin
                    state_d  = S_STOP;
                    bitcnt_d = '0;
                end else begin
                    bitcnt_d = bitcnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (!i1b) begin
                    state_d  = S_ERR;
                    bitcnt_d = '0;
                    ferr_d   = 1'b1;
                end else if (bitcnt_q == BC_W'(STOP_W - 1)) begin
                    state_d  = S_IDLE;
                    bitcnt_d = '0;
                    // Buffer is free if empty or being drained at this same edge.
                    if (!valid_q || iReady) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    bitcnt_d = bitcnt_q + 1'b1;
                end
            end
            S_ERR: begin
                if (i1b) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign oData       = data_q;
    assign oValid      = valid_q;
    assign oBusy       = (state_q != S_IDLE);
    assign oFrameErr   = ferr_q;
    assign oOverrun    = ovr_q;
    assign oFrameCount = cnt_q;

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Directed bench for s2p_frame_ctrl: bit-level frames with hand-computed words,
// buffer handshake, overrun, framing error, mid-frame reset and enable gating.
module tb_s2p_frame_ctrl;

    logic       Clock;
    logic       iReset;
    logic       i1b;
    logic       iEnable;
    logic       iReady;
    logic [7:0] oData;
    logic       oValid;
    logic       oBusy;
    logic       oFrameErr;
    logic       oOverrun;
    logic [7:0] oFrameCount;

    int total = 0;
    int bad   = 0;

    s2p_frame_ctrl #(.DATA_W(8), .STOP_W(2), .CNT_W(8)) dut (
        .Clock       (Clock),
        .iReset      (iReset),
        .i1b         (i1b),
        .iEnable     (iEnable),
        .iReady      (iReady),
        .oData       (oData),
        .oValid      (oValid),
        .oBusy       (oBusy),
        .oFrameErr   (oFrameErr),
        .oOverrun    (oOverrun),
        .oFrameCount (oFrameCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one bit, let one rising edge sample it, settle 1 time unit past it.
    task automatic send_bit(input logic b);
        i1b = b;
        @(posedge Clock);
        #1;
    endtask

    // Start bit, DATA_W data bits LSB first, then the two stop bits given.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop[0]);
        send_bit(stop[1]);
    endtask

    task automatic do_reset();
        i1b     = 1'b1;
        iEnable = 1'b1;
        iReset  = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        iReset = 1'b1;
    endtask

    initial begin
        i1b     = 1'b1;
        iEnable = 1'b1;
        iReady  = 1'b0;
        iReset  = 1'b0;

        // 1: reset state and idle line
        #2;
        check("rst_valid", oValid, 0);
        check("rst_busy", oBusy, 0);
        check("rst_data", oData, 0);
        check("rst_cnt", oFrameCount, 0);
        check("rst_ferr", oFrameErr, 0);
        check("rst_ovr", oOverrun, 0);
        do_reset();
        repeat (5) send_bit(1'b1);
        check("idle_busy", oBusy, 0);
        check("idle_valid", oValid, 0);

        // 2: single frame, consumer ready -> one-cycle valid
        iReady = 1'b1;
        send_bit(1'b0);
        check("t2_busy_after_start", oBusy, 1);
        for (int i = 0; i < 8; i++) send_bit(((8'h8B >> i) & 8'h01) != 0);
        send_bit(1'b1);
        check("t2_valid_early", oValid, 0);
        send_bit(1'b1);
        check("t2_valid", oValid, 1);
        check("t2_data", oData, 8'h8B);
        check("t2_cnt", oFrameCount, 1);
        check("t2_busy_done", oBusy, 0);
        send_bit(1'b1);
        check("t2_valid_clear", oValid, 0);

        // 3: buffer full -> overrun keeps old word
        do_reset();
        iReady = 1'b0;
        send_frame(8'h0F, 2'b11);
        check("t3_valid", oValid, 1);
        check("t3_data", oData, 8'h0F);
        send_frame(8'h61, 2'b11);
        check("t3_ovr", oOverrun, 1);
        check("t3_data_held", oData, 8'h0F);
        check("t3_cnt", oFrameCount, 1);
        check("t3_valid_held", oValid, 1);
        send_bit(1'b1);
        check("t3_ovr_pulse", oOverrun, 0);
        iReady = 1'b1;
        send_bit(1'b1);
        check("t3_valid_clear", oValid, 0);

        // 4: back-to-back frames, commits 11 edges apart
        do_reset();
        iReady = 1'b1;
        send_frame(8'h0F, 2'b11);
        check("t4_valid1", oValid, 1);
        check("t4_data1", oData, 8'h0F);
        send_bit(1'b0);
        check("t4_valid1_gap", oValid, 0);
        check("t4_busy_b2b", oBusy, 1);
        for (int i = 0; i < 8; i++) send_bit(((8'h61 >> i) & 8'h01) != 0);
        send_bit(1'b1);
        check("t4_valid2_early", oValid, 0);
        send_bit(1'b1);
        check("t4_valid2", oValid, 1);
        check("t4_data2", oData, 8'h61);
        check("t4_cnt", oFrameCount, 2);

        // 5: bad first stop bit, line held low in ERR, recovery
        do_reset();
        iReady = 1'b1;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(((8'h8B >> i) & 8'h01) != 0);
        send_bit(1'b0);
        check("t5_ferr", oFrameErr, 1);
        check("t5_valid", oValid, 0);
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b0);
            check("t5_err_busy", oBusy, 1);
        end
        check("t5_ferr_pulse", oFrameErr, 0);
        send_bit(1'b1);
        check("t5_idle", oBusy, 0);
        send_frame(8'h8B, 2'b11);
        check("t5_valid_rec", oValid, 1);
        check("t5_data_rec", oData, 8'h8B);
        check("t5_cnt", oFrameCount, 1);

        // 6a: reset mid-frame clears everything, next frame decodes
        do_reset();
        iReady = 1'b0;
        send_frame(8'hA5, 2'b11);
        check("t6_pre_cnt", oFrameCount, 1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        #2;
        iReset = 1'b0;
        #1;
        check("t6_rst_busy", oBusy, 0);
        check("t6_rst_valid", oValid, 0);
        check("t6_rst_data", oData, 0);
        check("t6_rst_cnt", oFrameCount, 0);
        @(posedge Clock);
        #1;
        iReset = 1'b1;
        i1b    = 1'b1;
        send_bit(1'b1);
        send_frame(8'h0F, 2'b11);
        check("t6_data", oData, 8'h0F);
        check("t6_valid", oValid, 1);
        check("t6_cnt", oFrameCount, 1);

        // 6b: start bit ignored while disabled
        do_reset();
        iEnable = 1'b0;
        send_bit(1'b0);
        check("t6_dis_busy", oBusy, 0);
        for (int i = 0; i < 10; i++) send_bit(1'b0);
        check("t6_dis_busy_end", oBusy, 0);
        check("t6_dis_valid", oValid, 0);

        // iEnable dropped after the start bit: the frame still completes
        i1b = 1'b1;
        iEnable = 1'b1;
        send_bit(1'b1);
        send_bit(1'b0);
        iEnable = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(((8'h3C >> i) & 8'h01) != 0);
        send_bit(1'b1);
        send_bit(1'b1);
        check("t6_midfr_valid", oValid, 1);
        check("t6_midfr_data", oData, 8'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
